// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    // Fetch-stage controller states.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Capture register for an instruction returned while the pipeline is stalled.
// Ports: clk, clr_n (async active-low clear), load (capture enable),
//        d_instr/d_pc4 (incoming instruction and PC+4), q_instr/q_pc4 (held copy).
module fetch_hold_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d_instr,
    input  logic [WIDTH-1:0] d_pc4,
    output logic [WIDTH-1:0] q_instr,
    output logic [WIDTH-1:0] q_pc4
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_instr <= '0;
            q_pc4   <= '0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc4   <= d_pc4;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds the IF/ID register, absorbing stalls and branch/jump redirects.
// Ports: clk, reset_b (async active-low); stall, redirect, redirect_pc from
//        hazard unit / EX; imem_req, imem_addr, imem_ack, imem_rdata to memory;
//        if_valid, if_instr, if_pc_plus4, ifid_en to the IF/ID register.
//        All outputs are combinational from state and inputs.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc_plus4,
    output logic             ifid_en
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    fetch_state_t     state, state_n;
    logic [WIDTH-1:0] pc, pc_n;
    logic [WIDTH-1:0] pend_pc, pend_pc_n;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] redirect_tgt;
    logic [WIDTH-1:0] hb_instr, hb_pc4;
    logic             hb_load;
    logic             unused_redirect_lsb;

    // Targets are word aligned; the low address bits are ignored.
    assign redirect_tgt        = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign pc_plus4            = pc + PC_STEP;

    fetch_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk     (clk),
        .clr_n   (reset_b),
        .load    (hb_load),
        .d_instr (imem_rdata),
        .d_pc4   (pc_plus4),
        .q_instr (hb_instr),
        .q_pc4   (hb_pc4)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pend_pc <= pend_pc_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        hb_load     = 1'b0;
        imem_req    = 1'b0;
        imem_addr   = '0;
        if_valid    = 1'b0;
        if_instr    = WIDTH'(NOP_INSTR);
        if_pc_plus4 = '0;
        ifid_en     = !stall || redirect;

        case (state)
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ack) begin
                    if_valid    = 1'b1;
                    if_instr    = imem_rdata;
                    if_pc_plus4 = pc_plus4;
                    if (redirect) begin
                        pc_n = redirect_tgt;
                    end else if (!stall) begin
                        pc_n = pc_plus4;
                    end else begin
                        hb_load = 1'b1;
                        state_n = HOLD;
                    end
                end else if (redirect) begin
                    // Outstanding request cannot be aborted; wait out its ack.
                    pend_pc_n = redirect_tgt;
                    state_n   = DRAIN;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (redirect) begin
                    pend_pc_n = redirect_tgt;
                end
                if (imem_ack) begin
                    pc_n    = redirect ? redirect_tgt : pend_pc;
                    state_n = FETCH;
                end
            end
            HOLD: begin
                if_valid    = 1'b1;
                if_instr    = hb_instr;
                if_pc_plus4 = hb_pc4;
                if (redirect) begin
                    pc_n    = redirect_tgt;
                    state_n = FETCH;
                end else if (!stall) begin
                    pc_n    = pc_plus4;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        // A redirect always turns the IF/ID load into a bubble.
        if (redirect) begin
            if_valid = 1'b0;
        end
        if (!if_valid) begin
            if_instr    = WIDTH'(NOP_INSTR);
            if_pc_plus4 = '0;
        end

        // Reset quiets every output immediately, without waiting for an edge.
        if (!reset_b) begin
            imem_req    = 1'b0;
            imem_addr   = '0;
            if_valid    = 1'b0;
            if_instr    = '0;
            if_pc_plus4 = '0;
            ifid_en     = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// run checked against a program-order stream model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic        ifid_en;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc_plus4 (if_pc_plus4),
        .ifid_en     (ifid_en)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_rdata = imem_ack ? mem_f(imem_addr) : 32'hDEAD_BEEF;

    task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] t);
        imem_ack    = a;
        stall       = s;
        redirect    = r;
        redirect_pc = t;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({imem_req, if_valid, ifid_en} !== 3'b000 || imem_addr !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: req=%b valid=%b en=%b addr=%h instr=%h pc4=%h, want all 0",
                     imem_req, if_valid, ifid_en, imem_addr, if_instr, if_pc_plus4);
        end
        step();
        reset_b = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_first_req: req=%b addr=%h, want 1 / 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks++;
            if (imem_addr !== 32'(4 * i) || if_pc_plus4 !== 32'(4 * i + 4) || if_valid !== 1'b1 ||
                ifid_en !== 1'b1 || if_instr !== mem_f(32'(4 * i))) begin
                n_errors++;
                $display("FAIL stream_%0d: addr=%h pc4=%h valid=%b en=%b instr=%h, want %h %h 1 1 %h",
                         i, imem_addr, if_pc_plus4, if_valid, ifid_en, if_instr,
                         32'(4 * i), 32'(4 * i + 4), mem_f(32'(4 * i)));
            end
            step();
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h10 || ifid_en !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_ack: addr=%h en=%b, want 00000010 0", imem_addr, ifid_en);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_instr !== mem_f(32'h10) ||
                if_pc_plus4 !== 32'h14 || ifid_en !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold_%0d: req=%b valid=%b instr=%h pc4=%h en=%b, want 0 1 %h 00000014 0",
                         k, imem_req, if_valid, if_instr, if_pc_plus4, ifid_en, mem_f(32'h10));
            end
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (ifid_en !== 1'b1 || if_valid !== 1'b1 || if_instr !== mem_f(32'h10) || imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_release: en=%b valid=%b instr=%h req=%b, want 1 1 %h 0",
                     ifid_en, if_valid, if_instr, imem_req, mem_f(32'h10));
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            n_errors++;
            $display("FAIL stall_next_addr: req=%b addr=%h, want 1 00000014", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        n_checks++;
        if (imem_addr !== 32'h20 || if_valid !== 1'b0 || ifid_en !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_enter: addr=%h valid=%b en=%b, want 00000020 0 1", imem_addr, if_valid, ifid_en);
        end
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            n_errors++;
            $display("FAIL drain_ack: req=%b addr=%h valid=%b instr=%h pc4=%h, want 1 00000020 0 0 0",
                     imem_req, imem_addr, if_valid, if_instr, if_pc_plus4);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL drain_target: req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_events();
        drive(1'b1, 1'b0, 1'b1, 32'h40);
        n_checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || ifid_en !== 1'b1) begin
            n_errors++;
            $display("FAIL redir_ack: valid=%b instr=%h en=%b, want 0 0 1", if_valid, if_instr, ifid_en);
        end
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL redir_ack_next: addr=%h, want 00000040", imem_addr);
        end
        step();
        drive(1'b0, 1'b1, 1'b1, 32'h80);
        n_checks++;
        if (ifid_en !== 1'b1 || if_instr !== 32'h0 || if_valid !== 1'b0 || if_pc_plus4 !== 32'h0) begin
            n_errors++;
            $display("FAIL redir_hold: en=%b instr=%h valid=%b pc4=%h, want 1 0 0 0", ifid_en, if_instr, if_valid, if_pc_plus4);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            n_errors++;
            $display("FAIL redir_hold_next: req=%b addr=%h, want 1 00000080", imem_req, imem_addr);
        end
    endtask

    task automatic test_double_redirect();
        drive(1'b0, 1'b0, 1'b1, 32'h200);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h302);
        n_checks++;
        if (imem_addr !== 32'h80 || imem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL dbl_drain_addr: req=%b addr=%h, want 1 00000080", imem_req, imem_addr);
        end
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (if_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL dbl_drain_drop: valid=%b, want 0", if_valid);
        end
        step();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        n_checks++;
        if (imem_addr !== 32'h300) begin
            n_errors++;
            $display("FAIL dbl_target: addr=%h, want 00000300", imem_addr);
        end
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_valid !== 1'b1 || if_instr !== mem_f(32'hFFFF_FFFC)) begin
            n_errors++;
            $display("FAIL wrap_deliver: addr=%h pc4=%h valid=%b instr=%h, want fffffffc 0 1 %h",
                     imem_addr, if_pc_plus4, if_valid, if_instr, mem_f(32'hFFFF_FFFC));
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_next: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b0, 1'b0, 1'b1, 32'h500);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        reset_b = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, if_valid, ifid_en} !== 3'b000 || imem_addr !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_async: req=%b valid=%b en=%b addr=%h instr=%h pc4=%h, want all 0",
                     imem_req, if_valid, ifid_en, imem_addr, if_instr, if_pc_plus4);
        end
        @(posedge clk);
        #2;
        reset_b = 1'b1;
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b1 || if_pc_plus4 !== 32'h4) begin
            n_errors++;
            $display("FAIL reset_release: req=%b addr=%h valid=%b pc4=%h, want 1 0 1 00000004",
                     imem_req, imem_addr, if_valid, if_pc_plus4);
        end
        step();
    endtask

    // Random traffic; the model only tracks which PC the next consumed
    // instruction must come from (program order, restarted by each redirect).
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] prev_addr;
        logic [31:0] tgt;
        logic        prev_pending;
        logic        busy;
        logic        a, s, r;
        int          cnt, lat, consumed;
        exp_next     = 32'h0;
        prev_addr    = 32'h0;
        prev_pending = 1'b0;
        busy         = 1'b0;
        cnt          = 0;
        lat          = 0;
        consumed     = 0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset_b = 1'b0;
        #1;
        reset_b = 1'b1;
        #1;
        for (int c = 0; c < 3000; c++) begin
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 9) == 0);
            tgt = 32'($urandom_range(0, 16383));
            a   = 1'b0;
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    lat  = $urandom_range(0, 3);
                end
                a = (cnt == lat);
            end
            drive(a, s, r, tgt);
            if (prev_pending) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    n_errors++;
                    $display("FAIL rnd_addr_stable c=%0d: req=%b addr=%h, want 1 %h", c, imem_req, imem_addr, prev_addr);
                end
            end
            n_checks++;
            if (ifid_en !== (!s || r)) begin
                n_errors++;
                $display("FAIL rnd_ifid_en c=%0d: en=%b, want %b", c, ifid_en, !s || r);
            end
            if (r) begin
                n_checks++;
                if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
                    n_errors++;
                    $display("FAIL rnd_redirect_bubble c=%0d: valid=%b instr=%h pc4=%h, want 0 0 0", c, if_valid, if_instr, if_pc_plus4);
                end
                exp_next = {tgt[31:2], 2'b00};
            end else if (!s) begin
                n_checks++;
                if (if_valid === 1'b1) begin
                    if (if_pc_plus4 !== exp_next + 32'd4 || if_instr !== mem_f(exp_next)) begin
                        n_errors++;
                        $display("FAIL rnd_stream c=%0d: pc4=%h instr=%h, want %h %h",
                                 c, if_pc_plus4, if_instr, exp_next + 32'd4, mem_f(exp_next));
                    end
                    exp_next = exp_next + 32'd4;
                    consumed++;
                end else if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin
                    n_errors++;
                    $display("FAIL rnd_bubble c=%0d: valid=%b instr=%h pc4=%h, want 0 0 0", c, if_valid, if_instr, if_pc_plus4);
                end
            end
            prev_pending = imem_req && !a;
            prev_addr    = imem_addr;
            if (a) busy = 1'b0;
            else if (busy) cnt++;
            step();
        end
        n_checks++;
        if (consumed < 300) begin
            n_errors++;
            $display("FAIL rnd_progress: consumed=%0d, want >= 300", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_redirect_events();
        test_double_redirect();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
